// File: rtl/reset_seq_pkg.sv
// Shared types and default sizing for the reset sequencer.
package reset_seq_pkg;

    // Global sequence phases.
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_HOLD_CYCLES    = 4;
    localparam int DEF_STAGGER_CYCLES = 2;

    // Width of the shared and local cycle counters.
    function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
        int m;
        m = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_hold_ctr.sv
// Per-channel local reset hold: stays high while req is high, then
// for HOLD_CYCLES more edges once req has fallen.
module rst_hold_ctr #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = $clog2(HOLD_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic req,
    output logic hold,
    output logic idle
);

    logic             hold_r = 1'b0;
    logic [CNT_W-1:0] lcnt   = '0;

    // Hold register and countdown; a re-request restarts the count from zero.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            hold_r <= 1'b0;
            lcnt   <= '0;
        end else if (req) begin
            hold_r <= 1'b1;
            lcnt   <= '0;
        end else if (hold_r) begin
            if (lcnt == CNT_W'(HOLD_CYCLES - 1)) begin
                hold_r <= 1'b0;
                lcnt   <= '0;
            end else begin
                lcnt <= lcnt + CNT_W'(1);
            end
        end
    end

    assign hold = hold_r;
    assign idle = ~hold_r;

endmodule

// File: rtl/reset_sequencer.sv
// Global reset sequencer: holds all channels in reset, then releases them
// one by one in ascending order; afterwards each channel can be locally
// re-held through its own rst_hold_ctr.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              soft_req,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int IDX_W = $clog2(NUM_CH) + 1;

    seq_state_t        state  = ASSERT;
    logic [CNT_W-1:0]  cnt    = '0;
    logic [IDX_W-1:0]  idx    = '0;
    logic [NUM_CH-1:0] mask   = '1;
    logic              done_r = 1'b0;

    seq_state_t        state_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [IDX_W-1:0]  idx_n;
    logic [NUM_CH-1:0] mask_n;
    logic              done_n;

    logic              in_done;
    logic [NUM_CH-1:0] hold_vec;
    logic [NUM_CH-1:0] unused_idle;

    // Sequencer registers; reset_n forces the power-up state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ASSERT;
            cnt    <= '0;
            idx    <= '0;
            mask   <= '1;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            mask   <= mask_n;
            done_r <= done_n;
        end
    end

    // Next-state logic: hold, then staggered releases, soft_req restarts.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        mask_n  = mask;
        done_n  = done_r;
        if (soft_req) begin
            state_n = ASSERT;
            cnt_n   = '0;
            idx_n   = '0;
            mask_n  = '1;
            done_n  = 1'b0;
        end else begin
            unique case (state)
                ASSERT: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        mask_n[0] = 1'b0;
                        cnt_n     = '0;
                        if (NUM_CH == 1) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = RELEASE;
                            idx_n   = IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (idx == IDX_W'(i)) begin
                                mask_n[i] = 1'b0;
                            end
                        end
                        cnt_n = '0;
                        if (idx == IDX_W'(NUM_CH - 1)) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = ASSERT;
                    cnt_n   = '0;
                    idx_n   = '0;
                    mask_n  = '1;
                    done_n  = 1'b0;
                end
            endcase
        end
    end

    // Local holds only run once the global sequence has finished; leaving
    // DONE (soft_req) discards anything in progress.
    assign in_done = (state == DONE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_hold
        rst_hold_ctr #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .CNT_W      (CNT_W)
        ) u_hold (
            .clk    (clk),
            .reset_n(reset_n),
            .clear  (soft_req | ~in_done),
            .req    (ch_req[g] & in_done),
            .hold   (hold_vec[g]),
            .idle   (unused_idle[g])
        );
    end

    assign rst_out = mask | hold_vec;
    assign done    = done_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized traffic,
// checked against a time-based model of the release schedule.
module tb_reset_sequencer;

    localparam int N  = 3;
    localparam int H  = 4;
    localparam int S  = 2;
    localparam int TD = H + (N - 1) * S;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         soft_req = 1'b0;
    logic [N-1:0] ch_req = '0;
    logic [N-1:0] rst_out;
    logic         done;

    logic         reset_n_b = 1'b0;
    logic         soft_req_b = 1'b0;
    logic [0:0]   ch_req_b = '0;
    logic [0:0]   rst_out_b;
    logic         done_b;

    int checks = 0;
    int errors = 0;

    // Model: edges counted since the sequence (re)started, and remaining
    // local hold edges per channel.
    int seq_t = 0;
    int lrem[N];

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_CH(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S)) dut (
        .clk(clk), .reset_n(reset_n), .soft_req(soft_req),
        .ch_req(ch_req), .rst_out(rst_out), .done(done)
    );

    reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .soft_req(soft_req_b),
        .ch_req(ch_req_b), .rst_out(rst_out_b), .done(done_b)
    );

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++)
            b[i] = (seq_t < H + i * S) || (lrem[i] > 0);
        return b;
    endfunction

    function automatic logic exp_done();
        return seq_t >= TD;
    endfunction

    task automatic model_edge(input logic rn, input logic sr, input logic [N-1:0] cr);
        bit in_done;
        if (!rn || sr) begin
            seq_t = 0;
            for (int i = 0; i < N; i++) lrem[i] = 0;
        end else begin
            in_done = (seq_t >= TD);
            for (int i = 0; i < N; i++) begin
                if (in_done) begin
                    if (cr[i]) lrem[i] = H;
                    else if (lrem[i] > 0) lrem[i] = lrem[i] - 1;
                end
            end
            if (seq_t < TD) seq_t = seq_t + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rn, input logic sr, input logic [N-1:0] cr);
        reset_n  = rn;
        soft_req = sr;
        ch_req   = cr;
        @(posedge clk);
        model_edge(rn, sr, cr);
        #1;
        chk("rst_out_model", 8'(rst_out), 8'(exp_rst()));
        chk("done_model", 8'(done), 8'(exp_done()));
    endtask

    initial begin
        for (int i = 0; i < N; i++) lrem[i] = 0;
        #1;
        chk("powerup_rst_out", 8'(rst_out), 8'h07);
        chk("powerup_done", 8'(done), 8'h0);

        // Power-up sequence; dut_b held in reset for the first two edges.
        step(1'b1, 1'b0, 3'b000);
        chk("b_in_reset_rst", 8'(rst_out_b), 8'h1);
        chk("b_in_reset_done", 8'(done_b), 8'h0);
        step(1'b1, 1'b0, 3'b000);
        reset_n_b = 1'b1;
        step(1'b1, 1'b0, 3'b000);
        chk("pu_edge3", 8'(rst_out), 8'h07);
        chk("b_release_rst", 8'(rst_out_b), 8'h0);
        chk("b_release_done", 8'(done_b), 8'h1);
        step(1'b1, 1'b0, 3'b000);
        chk("pu_edge4", 8'(rst_out), 8'h06);
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b000);
        chk("pu_edge6", 8'(rst_out), 8'h04);
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b000);
        chk("pu_edge8_rst", 8'(rst_out), 8'h00);
        chk("pu_edge8_done", 8'(done), 8'h1);

        // dut_b: soft_req restarts, one-cycle hold releases on the next edge.
        soft_req_b = 1'b1;
        step(1'b1, 1'b0, 3'b000);
        chk("b_soft_rst", 8'(rst_out_b), 8'h1);
        chk("b_soft_done", 8'(done_b), 8'h0);
        soft_req_b = 1'b0;
        step(1'b1, 1'b0, 3'b000);
        chk("b_resoft_rst", 8'(rst_out_b), 8'h0);
        chk("b_resoft_done", 8'(done_b), 8'h1);

        // Restart, then abort mid-sequence with reset_n at edge 7.
        step(1'b0, 1'b0, 3'b000);
        for (int e = 1; e <= 6; e++) step(1'b1, 1'b0, 3'b000);
        chk("pre_abort", 8'(rst_out), 8'h04);
        step(1'b0, 1'b0, 3'b000);
        chk("abort_rst", 8'(rst_out), 8'h07);
        chk("abort_done", 8'(done), 8'h0);
        step(1'b0, 1'b0, 3'b000);
        // Replay with ch_req[2] pulsed while in RELEASE.
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b0, (e == 5 || e == 6) ? 3'b100 : 3'b000);
            if (e == 4) chk("replay_edge4", 8'(rst_out), 8'h06);
            if (e == 6) chk("replay_edge6", 8'(rst_out), 8'h04);
        end
        chk("replay_edge8_rst", 8'(rst_out), 8'h00);
        chk("replay_edge8_done", 8'(done), 8'h1);

        // Local hold on channel 1.
        step(1'b1, 1'b0, 3'b010);
        chk("local_on", 8'(rst_out), 8'h02);
        for (int e = 1; e <= 4; e++) begin
            step(1'b1, 1'b0, 3'b000);
            chk("local_done_high", 8'(done), 8'h1);
            if (e == 3) chk("local_edge3", 8'(rst_out), 8'h02);
        end
        chk("local_cleared", 8'(rst_out), 8'h00);

        // Re-request during a hold restarts the count.
        step(1'b1, 1'b0, 3'b001);
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b001);
        for (int e = 1; e <= 3; e++) step(1'b1, 1'b0, 3'b000);
        chk("rereq_still_held", 8'(rst_out), 8'h01);
        step(1'b1, 1'b0, 3'b000);
        chk("rereq_cleared", 8'(rst_out), 8'h00);

        // soft_req beats ch_req; no residual local hold afterwards.
        step(1'b1, 1'b0, 3'b010);
        step(1'b1, 1'b1, 3'b001);
        chk("soft_win_rst", 8'(rst_out), 8'h07);
        chk("soft_win_done", 8'(done), 8'h0);
        for (int e = 1; e <= 8; e++) step(1'b1, 1'b0, 3'b000);
        chk("soft_seq_rst", 8'(rst_out), 8'h00);
        chk("soft_seq_done", 8'(done), 8'h1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic         rn, sr;
            logic [N-1:0] cr;
            rn = ($urandom_range(0, 99) >= 3);
            sr = ($urandom_range(0, 99) < 4);
            for (int i = 0; i < N; i++) cr[i] = ($urandom_range(0, 99) < 10);
            step(rn, sr, cr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
